// File: rtl/data_send.sv
// ==== data_send : streams NUM_DATA bytes from the result RAM to the UART TX core (rev 1.0) ====
`default_nettype none

module data_send #(
  parameter int NUM_DATA   = 2500,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  MEM_read_enable,
  output logic [ADDR_WIDTH-1:0] MEM_read_addr,
  input  logic [7:0]            MEM_read_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  finish,
  output logic                  send_finish_display
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  disp_q, disp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      disp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    disp_d     = disp_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) state_d = S_READ;
      end
      S_READ: state_d = S_WAIT_DATA;
      S_WAIT_DATA: begin
        // RAM output is held by the RAM itself, so waiting here is safe
        if (!tx_busy) begin
          tx_data_d  = MEM_read_data;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            disp_d  = ~disp_q;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_read_enable     = (state_q == S_READ);
  assign MEM_read_addr       = addr_q;
  assign tx_start            = tx_start_q;
  assign tx_data             = tx_data_q;
  assign finish              = (state_q == S_DONE);
  assign send_finish_display = disp_q;

endmodule

`default_nettype wire

// File: tb/tb_data_send.sv
// ==== tb_data_send : directed bench for data_send with RAM and UART TX models (rev 1.0) ====
`default_nettype none

module tb_data_send;

  localparam int NUM_DATA   = 4;
  localparam int ADDR_WIDTH = 4;
  localparam int LOG_SIZE   = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  MEM_read_enable;
  logic [ADDR_WIDTH-1:0] MEM_read_addr;
  logic [7:0]            MEM_read_data;
  logic                  tx_busy;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  finish;
  logic                  send_finish_display;

  data_send #(.NUM_DATA(NUM_DATA), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .MEM_read_enable     (MEM_read_enable),
    .MEM_read_addr       (MEM_read_addr),
    .MEM_read_data       (MEM_read_data),
    .tx_busy             (tx_busy),
    .tx_start            (tx_start),
    .tx_data             (tx_data),
    .finish              (finish),
    .send_finish_display (send_finish_display)
  );

  always #5 clk = ~clk;

  // Output-registered RAM: data updates only on a read, and is held otherwise.
  logic [7:0] ram [16];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) if (MEM_read_enable) ram_q <= ram[MEM_read_addr];
  assign MEM_read_data = ram_q;

  // UART TX model: busy rises ack_delay cycles after a launch, lasts busy_len cycles.
  int   ack_delay = 0;
  int   busy_len  = 10;
  logic force_busy = 1'b0;
  logic mbusy = 1'b0;
  logic pend  = 1'b0;
  int   acnt  = 0;
  int   bcnt  = 0;
  assign tx_busy = mbusy | force_busy;

  logic [7:0]            log_byte [LOG_SIZE];
  logic [ADDR_WIDTH-1:0] log_addr [LOG_SIZE];
  int   log_n      = 0;
  int   violations = 0;
  logic prev_start = 1'b0;

  always @(posedge clk) begin
    prev_start <= tx_start;
    if ((tx_start && tx_busy) || (tx_start && prev_start)) violations <= violations + 1;
    if (tx_start && log_n < LOG_SIZE) begin
      log_byte[log_n] <= tx_data;
      log_addr[log_n] <= MEM_read_addr;
      log_n           <= log_n + 1;
    end
    if (mbusy) begin
      if (bcnt <= 1) mbusy <= 1'b0;
      else           bcnt  <= bcnt - 1;
    end else if (tx_start) begin
      if (ack_delay == 0) begin
        mbusy <= 1'b1;
        bcnt  <= busy_len;
      end else begin
        pend <= 1'b1;
        acnt <= ack_delay - 1;
      end
    end else if (pend) begin
      if (acnt == 0) begin
        pend  <= 1'b0;
        mbusy <= 1'b1;
        bcnt  <= busy_len;
      end else begin
        acnt <= acnt - 1;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget && !finish; i++) tick();
    check("finish_reached", {31'd0, finish}, 32'd1);
  endtask

  task automatic wait_launches(input int target, input int budget);
    for (int i = 0; i < budget && log_n < target; i++) tick();
    check("launch_reached", {31'd0, (log_n >= target)}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] ram_w;        // byte 0 in bits [31:24]
    int          ack;
    int          blen;
    int          force_cycles;
    logic [31:0] exp_w;        // expected bytes, in send order
    logic        exp_disp;
  } vec_t;

  vec_t vecs [4];
  int   base;

  initial begin
    vecs[0] = '{32'h11223344, 0, 10, 0, 32'h11223344, 1'b1};
    vecs[1] = '{32'h11223344, 0, 10, 0, 32'h11223344, 1'b0};
    vecs[2] = '{32'hDEADBEEF, 5,  3, 0, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{32'h0180FF00, 1,  2, 8, 32'h0180FF00, 1'b0};

    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'hA5; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    // Reset state and first-byte latency
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("rst_read_en",  {31'd0, MEM_read_enable}, 32'd0);
    check("rst_addr",     {28'd0, MEM_read_addr}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    check("rst_finish",   {31'd0, finish}, 32'd0);
    check("rst_display",  {31'd0, send_finish_display}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    base  = log_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_read_en", {31'd0, MEM_read_enable}, 32'd1);
    tick();
    check("first_no_launch_yet", {31'd0, tx_start}, 32'd0);
    check("first_read_en_once",  {31'd0, MEM_read_enable}, 32'd0);
    tick();
    check("first_launch",  {31'd0, tx_start}, 32'd1);
    check("first_tx_data", {24'd0, tx_data}, 32'hA5);
    wait_finish(300);
    check("first_run_count", log_n - base, 32'd4);
    check("first_run_busy_low", {31'd0, tx_busy}, 32'd0);
    check("first_run_display", {31'd0, send_finish_display}, 32'd1);

    // Mid-run asynchronous reset during byte 2
    base  = log_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_launches(base + 2, 200);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("async_read_en",  {31'd0, MEM_read_enable}, 32'd0);
    check("async_addr",     {28'd0, MEM_read_addr}, 32'd0);
    check("async_tx_start", {31'd0, tx_start}, 32'd0);
    check("async_tx_data",  {24'd0, tx_data}, 32'd0);
    check("async_finish",   {31'd0, finish}, 32'd0);
    check("async_display",  {31'd0, send_finish_display}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("idle_after_reset_read_en", {31'd0, MEM_read_enable}, 32'd0);
    check("idle_after_reset_launch",  log_n - base, 32'd2);

    // Table-driven runs, each started from IDLE/DONE with a spurious mid-run start
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < NUM_DATA; j++) ram[j] = vecs[v].ram_w[31 - 8*j -: 8];
      ack_delay  = vecs[v].ack;
      busy_len   = vecs[v].blen;
      force_busy = (vecs[v].force_cycles > 0);
      base  = log_n;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("v%0d_finish_drop", v), {31'd0, finish}, 32'd0);
      check($sformatf("v%0d_read_en", v), {31'd0, MEM_read_enable}, 32'd1);
      if (vecs[v].force_cycles > 0) begin
        repeat (vecs[v].force_cycles) tick();
        check($sformatf("v%0d_launch_withheld", v), log_n - base, 32'd0);
        force_busy = 1'b0;
      end
      wait_launches(base + 2, 200);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_finish(400);
      check($sformatf("v%0d_count", v), log_n - base, 32'd4);
      for (int j = 0; j < NUM_DATA; j++) begin
        check($sformatf("v%0d_byte%0d", v, j), {24'd0, log_byte[base + j]},
              {24'd0, vecs[v].exp_w[31 - 8*j -: 8]});
        check($sformatf("v%0d_addr%0d", v, j), {28'd0, log_addr[base + j]}, j);
      end
      check($sformatf("v%0d_display", v), {31'd0, send_finish_display},
            {31'd0, vecs[v].exp_disp});
      repeat (5) tick();
      check($sformatf("v%0d_finish_hold", v), {31'd0, finish}, 32'd1);
      check($sformatf("v%0d_no_extra_launch", v), log_n - base, 32'd4);
    end

    check("launch_protocol_violations", violations, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
